// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: writeback source, multi-cycle source,
// register-file write port and arbiter status.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int NW = $clog2(DEPTH) + 1;

    logic          wb_regwrite;
    logic [4:0]    wb_writereg;
    logic [31:0]   wb_writedata;
    logic          mc_valid;
    logic          mc_ready;
    logic [4:0]    mc_writereg;
    logic [31:0]   mc_writedata;
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic          stall_req;
    logic [NW-1:0] fifo_count;

    modport master (
        output wb_regwrite, wb_writereg, wb_writedata,
        output mc_valid, mc_writereg, mc_writedata,
        input  mc_ready,
        input  rf_we, rf_wa, rf_wd,
        input  stall_req, fifo_count
    );

    modport slave (
        input  wb_regwrite, wb_writereg, wb_writedata,
        input  mc_valid, mc_writereg, mc_writedata,
        output mc_ready,
        output rf_we, rf_wa, rf_wd,
        output stall_req, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and a buffered
// multi-cycle result stream; requests a stall when the FIFO head starves.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [NW-1:0] FULL = NW'(DEPTH);
    localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_STALL
    } state_t;

    logic [4:0]    r_wa_mem [DEPTH];
    logic [31:0]   r_wd_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [NW-1:0] r_count;
    logic [SW-1:0] r_starve;
    state_t        r_state;

    state_t        w_next;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_blocked;
    logic [NW-1:0] w_count_nxt;
    logic [SW-1:0] w_starve_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL);
    assign w_pop     = !bus.wb_regwrite && !w_empty;
    assign w_blocked = bus.wb_regwrite && !w_empty;
    // Results to $0 complete the handshake but are dropped here.
    assign w_push    = bus.mc_valid && !w_full
                       && (bus.mc_writereg != 5'd0);

    assign w_count_nxt = r_count + NW'(w_push) - NW'(w_pop);

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || w_empty)
            w_starve_nxt = '0;
        else if (w_blocked && r_starve != LIM)
            w_starve_nxt = r_starve + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wa_mem[r_wr_ptr] <= bus.mc_writereg;
            r_wd_mem[r_wr_ptr] <= bus.mc_writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_push)
                    w_next = S_PENDING;
            end
            S_PENDING: begin
                if (w_count_nxt == '0)
                    w_next = S_IDLE;
                else if (w_starve_nxt == LIM)
                    w_next = S_STALL;
            end
            S_STALL: begin
                if (w_pop)
                    w_next = (w_count_nxt == '0)
                             ? S_IDLE : S_PENDING;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rf_we     = 1'b0;
        bus.rf_wa     = 5'd0;
        bus.rf_wd     = 32'd0;
        bus.stall_req = (r_state == S_STALL);
        if (bus.wb_regwrite) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = bus.wb_writereg;
            bus.rf_wd = bus.wb_writedata;
        end else if (!w_empty) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = r_wa_mem[r_rd_ptr];
            bus.rf_wd = r_wd_mem[r_rd_ptr];
        end
    end

    assign bus.mc_ready   = !w_full;
    assign bus.fifo_count = r_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: expected register-file writes go to a scoreboard queue,
// a negedge monitor pops and compares every write the DUT presents.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(2)) bus();

    wb_port_arbiter #(
        .DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got wa=%0d wd=%0h want none",
                         bus.rf_wa, bus.rf_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_wa", 32'(bus.rf_wa), 32'(e.wa));
                chk("rf_wd", bus.rf_wd, e.wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] r,
                      input logic [31:0] d);
        bus.wb_regwrite  = en;
        bus.wb_writereg  = r;
        bus.wb_writedata = d;
        if (en)
            exp_q.push_back('{wa: r, wd: d});
    endtask

    task automatic mc(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
        bus.mc_valid     = v;
        bus.mc_writereg  = r;
        bus.mc_writedata = d;
    endtask

    task automatic expect_wr(input logic [4:0] r,
                             input logic [31:0] d);
        exp_q.push_back('{wa: r, wd: d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        wb(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);

        // Writeback passes through even while held in reset.
        step();
        wb(1'b1, 5'd2, 32'h2222);
        step();
        wb(1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset_ready", 32'(bus.mc_ready), 32'd1);
        chk("reset_count", 32'(bus.fifo_count), 32'd0);
        chk("reset_stall", 32'(bus.stall_req), 32'd0);

        // Writeback priority over a same-cycle push.
        step();
        wb(1'b1, 5'd5, 32'h1234);
        mc(1'b1, 5'd7, 32'hAAAA);
        expect_wr(5'd7, 32'hAAAA);
        @(negedge clk);
        chk("prio_ready", 32'(bus.mc_ready), 32'd1);
        step();
        wb(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("prio_count1", 32'(bus.fifo_count), 32'd1);
        step();
        @(negedge clk);
        chk("prio_count0", 32'(bus.fifo_count), 32'd0);

        // Fill to full under writeback pressure.
        step();
        wb(1'b1, 5'd3, 32'h301);
        mc(1'b1, 5'd8, 32'h11);
        step();
        wb(1'b1, 5'd3, 32'h302);
        mc(1'b1, 5'd9, 32'h22);
        step();
        wb(1'b1, 5'd3, 32'h303);
        mc(1'b1, 5'd10, 32'h33);
        expect_wr(5'd8, 32'h11);
        expect_wr(5'd9, 32'h22);
        @(negedge clk);
        chk("full_count", 32'(bus.fifo_count), 32'd2);
        chk("full_ready", 32'(bus.mc_ready), 32'd0);
        step();
        wb(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("drain_ready0", 32'(bus.mc_ready), 32'd0);
        step();
        @(negedge clk);
        chk("drain_ready1", 32'(bus.mc_ready), 32'd1);
        chk("drain_count1", 32'(bus.fifo_count), 32'd1);
        step();
        @(negedge clk);
        chk("drain_count0", 32'(bus.fifo_count), 32'd0);

        // Starvation: one queued entry, writeback held busy.
        step();
        wb(1'b1, 5'd4, 32'h400);
        mc(1'b1, 5'd12, 32'h5555);
        for (int i = 1; i <= 6; i++) begin
            step();
            mc(1'b0, 5'd0, 32'd0);
            wb(1'b1, 5'd4, 32'h400 + 32'(i));
            @(negedge clk);
            chk($sformatf("starve_stall_%0d", i),
                32'(bus.stall_req), (i >= 5) ? 32'd1 : 32'd0);
        end
        expect_wr(5'd12, 32'h5555);
        step();
        wb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("bubble_stall", 32'(bus.stall_req), 32'd1);
        step();
        @(negedge clk);
        chk("release_stall", 32'(bus.stall_req), 32'd0);
        chk("release_count", 32'(bus.fifo_count), 32'd0);

        // Result to $0 is consumed but never written.
        step();
        mc(1'b1, 5'd0, 32'hDEAD);
        @(negedge clk);
        chk("zero_ready", 32'(bus.mc_ready), 32'd1);
        step();
        mc(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("zero_count", 32'(bus.fifo_count), 32'd0);
        chk("zero_rf_we", 32'(bus.rf_we), 32'd0);

        // Async reset while stalled with two entries queued.
        step();
        wb(1'b1, 5'd6, 32'h600);
        mc(1'b1, 5'd13, 32'h13);
        for (int i = 1; i <= 5; i++) begin
            step();
            wb(1'b1, 5'd6, 32'h600 + 32'(i));
            if (i == 1)
                mc(1'b1, 5'd14, 32'h14);
            else
                mc(1'b0, 5'd0, 32'd0);
        end
        @(negedge clk);
        chk("pre_rst_stall", 32'(bus.stall_req), 32'd1);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        #2;
        rst = 1'b1;
        bus.wb_regwrite = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall_req), 32'd0);
        chk("arst_count", 32'(bus.fifo_count), 32'd0);
        chk("arst_ready", 32'(bus.mc_ready), 32'd1);
        chk("arst_rf_we", 32'(bus.rf_we), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("post_count", 32'(bus.fifo_count), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
